// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : owner/tag types and latency legality helpers for mem_port_arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int c_MEM_LAT_MIN = 1;
  localparam int c_MEM_LAT_MAX = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   killed;
  } tag_t;

  localparam tag_t c_TAG_IDLE = '{valid: 1'b0, owner: OWN_IF, killed: 1'b0};

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= c_MEM_LAT_MIN) && (lat <= c_MEM_LAT_MAX);
  endfunction

  // A redirect only squashes fetch traffic; data tags pass through untouched.
  function automatic tag_t kill_fetch(input tag_t t, input logic kill);
    tag_t r;
    r = t;
    if (kill && t.valid && (t.owner == OWN_IF)) r.killed = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : fetch, data and memory-macro signals of mem_port_arbiter
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_if, stall_mem
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_resp_pipe.sv
// ---------------------------------------------------------------------------
// arb_resp_pipe : DEPTH-stage owner-tag shift register with fetch-kill marking
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  wire logic clk,
  input  wire logic resetn,
  input  wire tag_t i_push,
  input  wire logic i_kill,
  output tag_t      o_tag
);

  tag_t r_tags [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) r_tags[k] <= c_TAG_IDLE;
    end else begin
      r_tags[0] <= kill_fetch(i_push, i_kill);
      for (int k = 1; k < DEPTH; k++) r_tags[k] <= kill_fetch(r_tags[k-1], i_kill);
    end
  end

  assign o_tag = r_tags[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one pipelined single-port memory between fetch and
//                    data ports; optional fetch starvation guard enabled by
//                    macro MEM_ARB_STARVE_GUARD_EN
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  mem_port_arbiter_if.slave io_bus
);

  localparam int BE_W = DATA_W / 8;

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d is outside 1..4", MEM_LAT);
  end

  logic              w_force_if;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [BE_W-1:0]   w_mem_we;
  tag_t              w_push;
  tag_t              w_out;
  logic              w_resp_if;
  logic              w_resp_d;

  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX=%0d must be at least 1", STARVE_MAX);
  end

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_if = io_bus.if_req & ~io_bus.if_kill & io_bus.d_req &
                      (r_starve_cnt == CNT_W'(STARVE_MAX));

  // Counts consecutive data wins over a live fetch; any fetch grant or idle fetch restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (w_if_gnt || !io_bus.if_req) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && !io_bus.if_kill) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  if (STARVE_MAX < 0) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX=%0d must not be negative", STARVE_MAX);
  end

  assign w_force_if = 1'b0;
`endif

  always_comb begin
    w_d_gnt  = io_bus.d_req & ~w_force_if;
    w_if_gnt = io_bus.if_req & ~io_bus.if_kill & (~io_bus.d_req | w_force_if);

    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = '0;
    if (w_d_gnt) begin
      w_mem_addr  = io_bus.d_addr;
      w_mem_wdata = io_bus.d_wdata;
      if (io_bus.d_we) w_mem_we = io_bus.d_be;
    end else if (w_if_gnt) begin
      w_mem_addr = io_bus.if_addr;
    end

    w_push        = c_TAG_IDLE;
    w_push.valid  = w_if_gnt | (w_d_gnt & ~io_bus.d_we);
    w_push.owner  = w_d_gnt ? OWN_D : OWN_IF;
  end

  arb_resp_pipe #(
    .DEPTH (MEM_LAT)
  ) u_resp_pipe (
    .clk    (clk),
    .resetn (resetn),
    .i_push (w_push),
    .i_kill (io_bus.if_kill),
    .o_tag  (w_out)
  );

  // A kill arriving with the fetch response itself must also suppress it.
  assign w_resp_if = w_out.valid & ~w_out.killed & (w_out.owner == OWN_IF) & ~io_bus.if_kill;
  assign w_resp_d  = w_out.valid & ~w_out.killed & (w_out.owner == OWN_D);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= w_resp_if;
      r_d_rvalid  <= w_resp_d;
      if (w_resp_if) r_if_rdata <= io_bus.mem_rdata;
      if (w_resp_d)  r_d_rdata  <= io_bus.mem_rdata;
    end
  end

  assign io_bus.if_gnt    = w_if_gnt;
  assign io_bus.d_gnt     = w_d_gnt;
  assign io_bus.mem_en    = w_if_gnt | w_d_gnt;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;
  assign io_bus.stall_if  = io_bus.if_req & ~w_if_gnt;
  assign io_bus.stall_mem = io_bus.d_req & ~w_d_gnt;
  assign io_bus.if_rvalid = r_if_rvalid;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.d_rvalid  = r_d_rvalid;
  assign io_bus.d_rdata   = r_d_rdata;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, pipelined synchronous memory (BRAM-style, fixed read latency) between the pipeline's instruction-fetch port and data-access port. Arbitrates one access per cycle, tags every accepted access with its owner, and routes read data back to the correct requester. It exports per-port stall signals to the hazard unit, replacing the separate fetch and data stall sources. It sits between the IF/MEM pipeline stages and the unified memory macro.

## Interface
- ADDR_W, 14, word address width
- DATA_W, 64, data width; byte-enable width is DATA_W/8
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4; 0 is illegal
- STARVE_MAX, 4, maximum consecutive contested data grants before fetch is forced; used only with the guard macro

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_kill  in  1  redirect: squash fetch responses still in flight
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data, held until the next if_rvalid
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  byte enables for writes
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data, held until the next d_rvalid
- mem_en  out  1  memory enable
- mem_we  out  DATA_W/8  memory byte write enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- stall_if  out  1  if_req & ~if_gnt
- stall_mem  out  1  d_req & ~d_gnt

## Operation
- **Grant (combinational):**
  - d_req set → d_gnt = 1.
  - Otherwise, if_req set and if_kill clear → if_gnt = 1.
  - At most one grant per cycle.
  - if_kill = 1 forces if_gnt = 0 in that cycle.
- **Memory drive:**
  - Memory outputs come from the granted port.
  - mem_we = d_be when d_gnt & d_we, otherwise 0.
  - No grant → mem_en = 0; mem_addr and mem_wdata are don't-care.
- **Requester rule:** a requester keeps req, addr, we, be and wdata stable until it sees gnt. Deasserting req before gnt is allowed; that request is simply dropped.
- **Response pipeline:**
  - Every read grant (fetch, or data with d_we = 0) pushes a tag {valid, owner, killed = 0} into a MEM_LAT-deep shift register.
  - Writes and idle cycles push valid = 0.
- **if_kill:** sets killed on every in-flight fetch tag. A killed tag produces no if_rvalid.
- **Response:**
  - Tag at the output with valid & ~killed → the matching rvalid pulses for 1 cycle.
  - The matching rdata register captures mem_rdata on that same edge.
  - Writes return no rvalid; d_gnt is their completion.
- **Reset:**
  - resetn low asynchronously clears all tags, both rdata registers, and the starvation counter.
  - Reset mid-operation drops pending responses; no rvalid follows the release of reset.

## Timing
- Access granted at edge N → rvalid high during cycle N+MEM_LAT (after edge N+MEM_LAT), rdata valid in that same cycle.
- Throughput is one access per cycle, back-to-back, either owner.
- Reset values: if_rvalid = d_rvalid = 0, if_rdata = d_rdata = 0. Grants, mem_* and stall signals are combinational and follow the inputs; with no requests they are all 0.
- if_kill in the same cycle as a fetch response arriving suppresses that if_rvalid.
- An in-flight data tag is unaffected by if_kill.

## Configuration
- Macro: MEM_ARB_STARVE_GUARD_EN.
- **Defined:**
  - A counter increments on each cycle where d_gnt & if_req & ~if_kill.
  - When the counter equals STARVE_MAX, the next contested cycle grants fetch instead of data, and the counter clears.
  - The counter also clears on any if_gnt, or any cycle with if_req = 0.
- **Undefined:** data has strict priority, there is no counter, and STARVE_MAX is ignored.

## Structure
- Package mem_arb_pkg holds:
  - owner enum OWN_IF / OWN_D
  - tag struct {valid, owner, killed}
  - the MEM_LAT legality constant check
- One sub-module, arb_resp_pipe: the parameterized tag shift register with kill input. Grant logic, rdata capture and the guard counter stay in the top.

## Test plan
- **Idle fetch, MEM_LAT = 1:** if_req with if_addr = 0x10 → if_gnt the same cycle, mem_en = 1, mem_addr = 0x10; if_rvalid one cycle later with the word at 0x10; stall_if = 0.
- **Contention:** if_req and d_req (read, addr 0x20) together → d_gnt = 1, if_gnt = 0, stall_if = 1; fetch is granted the next cycle; the two responses arrive in grant order with the correct owners.
- **Write then read:** write 0xDEADBEEF_CAFEF00D with d_be = 0x0F to 0x30, then read 0x30 → no d_rvalid for the write; the read returns the upper 32 bits unchanged and the lower 32 bits = 0xCAFEF00D.
- **Kill:** MEM_LAT = 2; fetches granted at edges N and N+1; if_kill at N+1 → zero if_rvalid pulses, and if_rdata keeps its old value.
- **Starvation guard (macro defined, STARVE_MAX = 4):** d_req held high with if_req high → 4 consecutive d_gnt, then 1 if_gnt, then data resumes; without the macro, fetch is never granted.
- **Reset mid-flight:** resetn pulsed low while 2 reads are in flight → no rvalid after release, and the rdata outputs are 0.
